inst_encoder_rv32: RTL and testbench

- Inverse of the RV32 decode stage: accepts decoded micro-op fields over a val/rdy request interface and emits the 32-bit RV32 instruction word over a val/rdy response interface.
- Used by test-program generators and by the fetch-side stimulus harness to build instruction streams from uop descriptions.
- Results are held in a small output queue, so the producer is decoupled from the consumer.

---
 rtl/inst_encoder_rv32.sv | 144 ++++++++++++++
 tb/tb_inst_encoder_rv32.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_rv32.sv
// rtl/inst_encoder_rv32.sv - RV32 instruction encoder: uop fields in, 32-bit instruction word out
//
// Purpose: builds RV32 ADD / ADDI / MUL instruction words from decoded
// micro-op fields and holds them in a small FIFO for the consumer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_val/req_rdy   request handshake (req_rdy = queue not full)
//   req_uop, req_rs1, req_rs2, req_rd, req_imm, req_op2_sel  uop fields
//   resp_val/resp_rdy response handshake
//   resp_inst         encoded instruction (0 when the uop was not encodable)
//   resp_err          uop was not encodable
//   num_encoded       saturating count of consumed error-free responses

package inst_encoder_rv32_pkg;
  typedef logic [3:0] rv_uop;

  localparam rv_uop OP_ADD = 4'd0;
  localparam rv_uop OP_MUL = 4'd1;

  localparam logic [31:0] OP_ADD_VEC = 32'h0000_0001;
  localparam logic [31:0] OP_MUL_VEC = 32'h0000_0002;
  localparam logic [31:0] p_tinyrv1  = OP_ADD_VEC | OP_MUL_VEC;
endpackage

module inst_encoder_rv32
  import inst_encoder_rv32_pkg::*;
#(
  parameter logic [31:0] p_isa_subset  = p_tinyrv1,
  parameter int          p_num_entries = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_val,
  output logic        req_rdy,
  input  rv_uop       req_uop,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_imm,
  input  logic        req_op2_sel,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  output logic [15:0] num_encoded
);

  localparam int AW = $clog2(p_num_entries);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_MUL     = 7'b0000001;

  localparam logic w_add_en = (p_isa_subset & OP_ADD_VEC) != 32'h0;
  localparam logic w_mul_en = (p_isa_subset & OP_MUL_VEC) != 32'h0;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [31:0]  r_inst [p_num_entries];
  logic         r_err  [p_num_entries];
  logic [15:0]  r_num_encoded;

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic [31:0]  w_inst;
  logic         w_err;
  logic         w_imm_fits;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Readiness depends only on stored occupancy, never on resp_rdy.
  assign req_rdy = !w_full;
  assign w_push  = req_val && !w_full;
  assign w_pop   = !w_empty && resp_rdy;

  // Immediate fits in 12 bits when bits 31..11 are all copies of the sign.
  assign w_imm_fits = (req_imm[31:11] == {21{req_imm[11]}});

  always_comb begin
    w_inst = 32'h0;
    w_err  = 1'b0;
    case (req_uop)
      OP_ADD: begin
        if (!w_add_en) begin
          w_err = 1'b1;
        end else if (req_op2_sel) begin
          if (w_imm_fits) begin
            w_inst = {req_imm[11:0], req_rs1, F3_ADD, req_rd, OPC_OP_IMM};
          end else begin
            w_err = 1'b1;
          end
        end else begin
          w_inst = {F7_ADD, req_rs2, req_rs1, F3_ADD, req_rd, OPC_OP};
        end
      end
      OP_MUL: begin
        if (!w_mul_en || req_op2_sel) begin
          w_err = 1'b1;
        end else begin
          w_inst = {F7_MUL, req_rs2, req_rs1, F3_ADD, req_rd, OPC_OP};
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_num_encoded <= 16'h0;
      for (int i = 0; i < p_num_entries; i++) begin
        r_inst[i] <= 32'h0;
        r_err[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_inst[r_wr_ptr[AW-1:0]] <= w_inst;
        r_err[r_wr_ptr[AW-1:0]]  <= w_err;
        r_wr_ptr                 <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (!r_err[r_rd_ptr[AW-1:0]] && (r_num_encoded != 16'hFFFF)) begin
          r_num_encoded <= r_num_encoded + 16'h1;
        end
      end
    end
  end

  // Outputs read zero while empty so the post-reset state is clean.
  assign resp_val    = !w_empty;
  assign resp_inst   = w_empty ? 32'h0 : r_inst[r_rd_ptr[AW-1:0]];
  assign resp_err    = w_empty ? 1'b0  : r_err[r_rd_ptr[AW-1:0]];
  assign num_encoded = r_num_encoded;

endmodule

// File: tb/tb_inst_encoder_rv32.sv
// tb/tb_inst_encoder_rv32.sv - directed self-checking bench for inst_encoder_rv32
module tb_inst_encoder_rv32;
  import inst_encoder_rv32_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_val;
  logic        req_rdy;
  rv_uop       req_uop;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rd;
  logic [31:0] req_imm;
  logic        req_op2_sel;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic [15:0] num_encoded;

  logic        req_rdy_b;
  logic        resp_val_b;
  logic [31:0] resp_inst_b;
  logic        resp_err_b;
  logic [15:0] num_encoded_b;

  int vectors;
  int miscompares;

  inst_encoder_rv32 #(.p_isa_subset(p_tinyrv1), .p_num_entries(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_uop(req_uop),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_imm(req_imm), .req_op2_sel(req_op2_sel),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_inst(resp_inst),
    .resp_err(resp_err), .num_encoded(num_encoded)
  );

  // Same stimulus, but MUL is excluded from the ISA subset.
  inst_encoder_rv32 #(.p_isa_subset(OP_ADD_VEC), .p_num_entries(2)) dut_nomul (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy_b), .req_uop(req_uop),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_imm(req_imm), .req_op2_sel(req_op2_sel),
    .resp_val(resp_val_b), .resp_rdy(resp_rdy), .resp_inst(resp_inst_b),
    .resp_err(resp_err_b), .num_encoded(num_encoded_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input rv_uop uop, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic sel);
    req_uop = uop; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    req_imm = imm; req_op2_sel = sel;
  endtask

  // Called at posedge+1; fires one request at the next edge, returns at posedge+1.
  task automatic issue(input rv_uop uop, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic sel);
    set_req(uop, rs1, rs2, rd, imm, sel);
    req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req_val = 1'b0;
    resp_rdy = 1'b0;
    set_req(OP_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_num", 32'(num_encoded), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_resp_inst", resp_inst, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    // ADD x3, x1, x2
    resp_rdy = 1'b1;
    issue(OP_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    chk("add_val", 32'(resp_val), 32'd1);
    chk("add_inst", resp_inst, 32'h002081B3);
    chk("add_err", 32'(resp_err), 32'd0);
    chk("add_inst_b", resp_inst_b, 32'h002081B3);
    step();
    chk("add_drained", 32'(resp_val), 32'd0);
    chk("add_num", 32'(num_encoded), 32'd1);

    // ADDI x5, x0, -1
    issue(OP_ADD, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b1);
    chk("addi_inst", resp_inst, 32'hFFF00293);
    chk("addi_err", 32'(resp_err), 32'd0);
    step();
    chk("addi_num", 32'(num_encoded), 32'd2);

    // ADDI with immediate 2048 is out of range
    issue(OP_ADD, 5'd0, 5'd0, 5'd5, 32'd2048, 1'b1);
    chk("addi2048_err", 32'(resp_err), 32'd1);
    chk("addi2048_inst", resp_inst, 32'h0);
    step();
    chk("addi2048_num", 32'(num_encoded), 32'd2);

    // ADDI at the range edges -2048 and 2047
    issue(OP_ADD, 5'd0, 5'd0, 5'd1, 32'hFFFF_F800, 1'b1);
    chk("addi_m2048_inst", resp_inst, 32'h80000093);
    step();
    issue(OP_ADD, 5'd0, 5'd0, 5'd1, 32'd2047, 1'b1);
    chk("addi_2047_inst", resp_inst, 32'h7FF00093);
    step();
    chk("addi_edges_num", 32'(num_encoded), 32'd4);

    // MUL x10, x11, x12; excluded from the second instance's subset
    issue(OP_MUL, 5'd11, 5'd12, 5'd10, 32'h0, 1'b0);
    chk("mul_inst", resp_inst, 32'h02C58533);
    chk("mul_err", 32'(resp_err), 32'd0);
    chk("mul_nomul_err", 32'(resp_err_b), 32'd1);
    chk("mul_nomul_inst", resp_inst_b, 32'h0);
    step();
    chk("mul_num", 32'(num_encoded), 32'd5);

    // MUL with immediate operand and an unknown uop are errors
    issue(OP_MUL, 5'd11, 5'd12, 5'd10, 32'h5, 1'b1);
    chk("muli_err", 32'(resp_err), 32'd1);
    step();
    issue(4'd7, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    chk("unknown_err", 32'(resp_err), 32'd1);
    chk("unknown_inst", resp_inst, 32'h0);
    step();
    chk("err_num", 32'(num_encoded), 32'd5);

    // Backpressure: rd=1, rd=2 accepted, rd=3 stalls
    resp_rdy = 1'b0;
    issue(OP_ADD, 5'd1, 5'd2, 5'd1, 32'h0, 1'b0);
    issue(OP_ADD, 5'd1, 5'd2, 5'd2, 32'h0, 1'b0);
    chk("bp_full_rdy", 32'(req_rdy), 32'd0);
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    req_val = 1'b1;
    step();
    chk("bp_hold_inst", resp_inst, 32'h002080B3);
    chk("bp_still_full", 32'(req_rdy), 32'd0);
    resp_rdy = 1'b1;
    chk("bp_full_with_rdy", 32'(req_rdy), 32'd0);
    step();
    chk("bp_second", resp_inst, 32'h00208133);
    step();
    req_val = 1'b0;
    chk("bp_third", resp_inst, 32'h002081B3);
    step();
    chk("bp_drained", 32'(resp_val), 32'd0);
    chk("bp_num", 32'(num_encoded), 32'd8);

    // Streaming: eight back-to-back requests with rd = 1..8
    for (int i = 1; i <= 8; i++) begin
      set_req(OP_ADD, 5'd1, 5'd2, 5'(i), 32'h0, 1'b0);
      req_val = 1'b1;
      step();
      chk("stream_val", 32'(resp_val), 32'd1);
      chk("stream_inst", resp_inst, 32'h00208033 | (32'(i) << 7));
    end
    req_val = 1'b0;
    step();
    chk("stream_drained", 32'(resp_val), 32'd0);
    chk("stream_num", 32'(num_encoded), 32'd16);

    // Reset with two entries queued
    resp_rdy = 1'b0;
    issue(OP_ADD, 5'd1, 5'd2, 5'd1, 32'h0, 1'b0);
    issue(OP_ADD, 5'd1, 5'd2, 5'd2, 32'h0, 1'b0);
    chk("prerst_full", 32'(req_rdy), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_val", 32'(resp_val), 32'd0);
    chk("async_rst_num", 32'(num_encoded), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    step();
    resp_rdy = 1'b1;
    issue(OP_MUL, 5'd11, 5'd12, 5'd10, 32'h0, 1'b0);
    chk("postrst_inst", resp_inst, 32'h02C58533);
    step();
    chk("postrst_alone", 32'(resp_val), 32'd0);
    chk("postrst_num", 32'(num_encoded), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
